// File: rtl/aes_128_inv.sv
// Iterative AES-128 decryption: forward key expansion to k10, then one inverse round per cycle while unwinding the key schedule.
// Optional macro AES_128_INV_KEY_CACHE_EN keeps the last expanded key/k10 so a repeated key skips EXPAND (latency 10 instead of 20).
module aes_128_inv (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         out_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} fsm_e;

  fsm_e         fsm_q;
  logic         start_q;
  logic [3:0]   rnd_q;
  logic [127:0] ct_q;
  logic [127:0] rk_q;
  logic [127:0] s_q;
  logic [127:0] out_q;
  logic         out_valid_q;
  logic         busy_q;

`ifdef AES_128_INV_KEY_CACHE_EN
  logic [127:0] cache_key_q;
  logic [127:0] cache_k10_q;
  logic         cache_vld_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = a;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0]  ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  // Byte i = row + 4*col, byte 0 in the MSBs.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        b[rw+4*c] = inv_sbox(s[127-8*(rw+4*((c-rw+4)%4)) -: 8]) ^ k[127-8*(rw+4*c) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        if (last) r[127-8*(rw+4*c) -: 8] = b[rw+4*c];
        else r[127-8*(rw+4*c) -: 8] = gf_mul(8'h0e, b[4*c+rw])       ^ gf_mul(8'h0b, b[4*c+(rw+1)%4]) ^
                                      gf_mul(8'h0d, b[4*c+(rw+2)%4]) ^ gf_mul(8'h09, b[4*c+(rw+3)%4]);
      end
    end
    return r;
  endfunction

  logic         start_edge;
  logic [127:0] k_fwd;
  logic [127:0] k_inv;
  logic [127:0] round_out;

  assign start_edge = start & ~start_q;
  assign k_fwd      = fwd_expand(rk_q, rcon(rnd_q));
  assign k_inv      = inv_expand(rk_q, rcon(rnd_q + 4'd1));
  assign round_out  = inv_round(s_q, k_inv, rnd_q == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      start_q     <= 1'b0;
      rnd_q       <= 4'd0;
      ct_q        <= '0;
      rk_q        <= '0;
      s_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_128_INV_KEY_CACHE_EN
      cache_key_q <= '0;
      cache_k10_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      start_q <= start;
      case (fsm_q)
        IDLE, DONE: begin
          if (start_edge) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            ct_q        <= state;
            rk_q        <= key;
            rnd_q       <= 4'd1;
            fsm_q       <= EXPAND;
`ifdef AES_128_INV_KEY_CACHE_EN
            // A hit overrides the default expand path with the stored k10.
            if (cache_vld_q && key == cache_key_q) begin
              s_q   <= state ^ cache_k10_q;
              rk_q  <= cache_k10_q;
              rnd_q <= 4'd9;
              fsm_q <= DECRYPT;
            end else begin
              cache_key_q <= key;
              cache_vld_q <= 1'b0;
            end
`endif
          end
        end
        EXPAND: begin
          rk_q <= k_fwd;
          if (rnd_q == 4'd10) begin
            s_q   <= ct_q ^ k_fwd;
            rnd_q <= 4'd9;
            fsm_q <= DECRYPT;
`ifdef AES_128_INV_KEY_CACHE_EN
            cache_k10_q <= k_fwd;
            cache_vld_q <= 1'b1;
`endif
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DECRYPT: begin
          if (rnd_q == 4'd0) begin
            out_q       <= round_out;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            fsm_q       <= DONE;
          end else begin
            s_q   <= round_out;
            rk_q  <= k_inv;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_128_inv.sv
// Bench for aes_128_inv: scoreboard of expected plaintext/latency, checked by a monitor on each out_valid rise.
// Random vectors are produced by encrypting random plaintext with a table-driven forward AES model.
module tb_aes_128_inv;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] state_i = '0;
  logic [127:0] key_i = '0;
  logic [127:0] out;
  logic         out_valid;
  logic         busy;

  always #5 clk = ~clk;

  aes_128_inv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .state    (state_i),
    .key      (key_i),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy)
  );

  localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPT  = 128'h3243f6a8885a308d313198a2e0370734;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [127:0] pt; int lat; int acc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic         mc_vld = 1'b0;
  logic [127:0] mc_key = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  logic [7:0] sbt [256];

  task automatic build_sbox();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbt[x] = s;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   nx [16];
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) nx[i] = sbt[st[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          if (rd < 10) st[4*c+j] = gm(8'h02, nx[4*c+j]) ^ gm(8'h03, nx[4*c+(j+1)%4]) ^
                                   nx[4*c+(j+2)%4] ^ nx[4*c+(j+3)%4];
          else st[4*c+j] = nx[4*c+j];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st[i];
    return r;
  endfunction

  task automatic model_accept(input logic [127:0] k, output int lat);
    lat = 20;
`ifdef AES_128_INV_KEY_CACHE_EN
    if (mc_vld && k == mc_key) lat = 10;
    else begin
      mc_vld = 1'b1;
      mc_key = k;
    end
`endif
  endtask

  task automatic issue(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    model_accept(k, lat);
    key_i   = k;
    state_i = ct;
    start   = 1'b1;
    tick();
    sb.push_back('{pt, lat, cyc});
    start   = 1'b0;
    state_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("busy_on_accept", 128'(busy), 128'(1'b1));
    chk("valid_drop_on_accept", 128'(out_valid), 128'(1'b0));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  logic vld_prev = 1'b0;
  always @(negedge clk) begin
    if (out_valid === 1'b1 && vld_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: out=%h with no request outstanding", out);
      end else begin
        mon_e = sb.pop_front();
        chk("plaintext", out, mon_e.pt);
        chk("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
        chk("busy_clear_at_done", 128'(busy), 128'(1'b0));
      end
    end
    vld_prev = out_valid;
  end

  initial begin
    int lat;
    logic [127:0] rk, rp, prevk;
    build_sbox();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_out", out, 128'h0);
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_busy", 128'(busy), 128'(1'b0));
    rst_n = 1'b1;
    tick();

    // C.1 run interrupted by reset on the 12th edge after accept.
    issue(C1K, C1CT, C1PT);
    repeat (11) tick();
    rst_n = 1'b0;
    tick();
    chk("midrun_reset_out", out, 128'h0);
    chk("midrun_reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midrun_reset_busy", 128'(busy), 128'(1'b0));
    rst_n = 1'b1;
    sb.delete();
    mc_vld = 1'b0;
    tick();

    // Fresh C.1 run with busy tracked every cycle.
    issue(C1K, C1CT, C1PT);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("c1_busy_during_run", 128'(busy), 128'(1'b1));
    end
    tick();
    chk("c1_out_valid_at_20", 128'(out_valid), 128'(1'b1));
    wait_done(5);

    issue(BK, BCT, BPT);
    wait_done(30);

    // Back-to-back: new accept in DONE keeps the previous plaintext on out.
    issue(C1K, C1CT, C1PT);
    for (int i = 1; i < 20; i++) begin
      tick();
      if (i == 1 || i == 10 || i == 19) chk("hold_prev_out", out, BPT);
    end
    wait_done(10);

    // Start held high with an extra rising edge while busy.
    model_accept(C1K, lat);
    key_i   = C1K;
    state_i = C1CT;
    start   = 1'b1;
    tick();
    sb.push_back('{C1PT, lat, cyc});
    for (int i = 1; i < 50; i++) begin
      start = (i != 4);
      tick();
    end
    chk("held_start_single_result", 128'(sb.size()), 128'(0));
    chk("held_start_valid_stays", 128'(out_valid), 128'(1'b1));
    chk("held_start_not_busy", 128'(busy), 128'(1'b0));
    chk("held_start_out", out, C1PT);
    start = 1'b0;
    tick();

    issue(BK, BCT, BPT);
    wait_done(30);

    prevk = BK;
    for (int n = 0; n < 24; n++) begin
      rk = ($urandom_range(0, 2) == 0) ? prevk : {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      issue(rk, encrypt(rk, rp), rp);
      wait_done(30);
      repeat ($urandom_range(0, 3)) tick();
      prevk = rk;
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
